stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
//
// PURPOSE
//   Downstream consumer of the divider's div_clock output. Samples the slow
//   divided clock in the system clock domain and turns each rising edge into
//   a one-cycle tick. Counts ticks as a multi-digit BCD stopwatch with
//   start/stop/clear control, and drives the seven-segment decode stage.
//
// PARAMETERS
//   DIGITS       4   number of BCD digits; the count range is 0 .. 10^DIGITS-1
//   SYNC_STAGES  2   synchroniser flops on div_clock; minimum 2
//
// PORTS
//   clock        in   1          system clock (10 MHz on the board)
//   reset_n      in   1          asynchronous, active-low reset
//   div_clock    in   1          slow divided clock from the divider; treated as asynchronous
//   start_stop   in   1          one-cycle pulse (already debounced); toggles run/pause
//   clear        in   1          one-cycle pulse; zeroes the count and returns to IDLE
//   bcd          out  4*DIGITS   count value; digit 0 is in bits [3:0]
//   running      out  1          high while the FSM is in RUN
//   rollover     out  1          one-cycle pulse when the count wraps from all-9s to 0
//
// BEHAVIOUR
//   - Reset (reset_n=0, async):
//       * synchroniser flops and edge register = 0
//       * state = IDLE
//       * bcd = 0, running = 0, rollover = 0
//   - Tick generation:
//       * div_clock passes through SYNC_STAGES flops; edge register prev = last sync output.
//       * tick = sync_out & ~prev.
//       * If div_clock is sampled high at clock edge E0, the count updates at edge E(SYNC_STAGES).
//       * One tick per div_clock rising edge. A level held high gives no further ticks.
//   - FSM states: IDLE, RUN, PAUSE.
//       * IDLE  --start_stop--> RUN
//       * RUN   --start_stop--> PAUSE
//       * PAUSE --start_stop--> RUN
//       * any state --clear--> IDLE
//   - Counting:
//       * The count increments only when state==RUN and tick==1.
//       * A tick in the same cycle as RUN->PAUSE is counted.
//       * A tick in the same cycle as IDLE->RUN or PAUSE->RUN is not counted.
//       * A spurious tick just after reset (div_clock already high) is ignored because the FSM is in IDLE.
//   - Priority: clear > tick > start_stop.
//       * clear with tick: the count becomes 0, not 1.
//       * clear with start_stop: the next state is IDLE.
//   - BCD arithmetic:
//       * Each digit counts 0..9. Digit 9 plus carry gives 0 and carries into the next digit.
//       * Digit values 10..15 never occur.
//   - Wrap:
//       * all digits 9 + counted tick -> bcd = 0 and rollover = 1 for exactly one cycle.
//       * The FSM stays in RUN.
//   - Outputs: all registered; running is registered from the next state.
//   - IDLE holds bcd = 0. PAUSE holds the last count.
//   - Reset asserted mid-count: immediate async return to the reset values above; no tick is pending.
//
// CONFIGURATION
//   LAP_HOLD_EN defined:
//     - Adds input lap (one-cycle pulse) and output lap_active.
//     - lap in RUN toggles hold.
//     - While hold is set:
//         * bcd shows the snapshot taken at the lap pulse; the internal count keeps running.
//         * rollover still reflects the internal count.
//     - Releasing hold updates bcd to the live count on the next edge.
//     - lap is ignored in IDLE/PAUSE.
//     - clear or reset releases hold; lap_active resets to 0.
//   LAP_HOLD_EN undefined:
//     - No lap/lap_active ports; bcd always shows the live count.
//
// TESTING   (clock period 100 ns, DIGITS=4, SYNC_STAGES=2)
//   1. reset_n low with div_clock toggling -> bcd=16'h0000, running=0, rollover=0.
//      Release reset, no start_stop, 20 div_clock edges -> bcd stays 16'h0000.
//   2. start_stop pulse, then 12 div_clock rising edges -> bcd=16'h0012, running=1.
//      Each increment lands 2 clock edges after the first sample of div_clock high.
//   3. In RUN at 16'h0012, start_stop pulse -> running=0.
//      5 more div_clock edges -> bcd=16'h0012.
//      start_stop again, 3 edges -> bcd=16'h0015.
//   4. Run a fast div_clock up to 16'h9999; next rising edge -> bcd=16'h0000,
//      rollover high exactly 1 cycle, running stays 1.
//   5. At 16'h0042 in RUN, assert clear, tick and start_stop in the same cycle
//      -> next edge bcd=16'h0000, running=0 (IDLE).
//   6. LAP_HOLD_EN: in RUN at 16'h0005, lap pulse, 3 ticks -> bcd=16'h0005, lap_active=1.
//      lap pulse again -> bcd=16'h0008, lap_active=0.

Source files
------------

// File: rtl/stopwatch_counter.sv
// BCD stopwatch driven by the divider's slow div_clock: synchronise, edge-detect, count.
// Optional lap/hold display freeze is compiled in when LAP_HOLD_EN is defined.
module stopwatch_counter #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                div_clock,
  input  logic                start_stop,
  input  logic                clear,
`ifdef LAP_HOLD_EN
  input  logic                lap,
  output logic                lap_active,
`endif
  output logic [4*DIGITS-1:0] bcd,
  output logic                running,
  output logic                rollover
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick;
  logic                   counted;
  logic                   wrap;
  logic [W-1:0]           count_q, count_d;

  // Ripple-carry BCD increment; a digit at 9 wraps to 0 and passes the carry upward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // div_clock is asynchronous to clock, so it only enters logic after the sync chain.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_clock};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    // NOTE: defaults first so no path leaves state_d unassigned (that would infer a latch).
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counting uses the current state, so a tick on the cycle leaving RUN still counts
  // and a tick on the cycle entering RUN does not.
  assign counted = (state_q == RUN) && tick && !clear;
  assign wrap    = counted && (count_q == ALL_NINES);

  always_comb begin
    count_d = count_q;
    if (clear)        count_d = '0;
    else if (counted) count_d = bcd_inc(count_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      running  <= 1'b0;
      rollover <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      running  <= (state_d == RUN);
      rollover <= wrap;
    end
  end

`ifdef LAP_HOLD_EN
  logic         hold_q, hold_d;
  logic [W-1:0] snap_q, snap_d;
  logic [W-1:0] shown_q;

  // Lap toggles the display freeze; the snapshot is the count visible at the lap pulse.
  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (lap && (state_q == RUN)) begin
      hold_d = !hold_q;
      if (!hold_q) snap_d = count_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= 1'b0;
      snap_q  <= '0;
      shown_q <= '0;
    end else begin
      hold_q  <= hold_d;
      snap_q  <= snap_d;
      shown_q <= hold_d ? snap_d : count_d;
    end
  end

  assign bcd        = shown_q;
  assign lap_active = hold_q;
`else
  assign bcd = count_q;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: integer reference model compared every cycle,
// plus literal expectations at the scenario checkpoints.
module tb_stopwatch_counter;

  localparam int DIGITS = 4;
  localparam int MAXC   = 9999;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b1;
  logic        div_clock  = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear      = 1'b0;
  logic [15:0] bcd;
  logic        running;
  logic        rollover;
`ifdef LAP_HOLD_EN
  logic        lap = 1'b0;
  logic        lap_active;
`endif

  stopwatch_counter #(.DIGITS(DIGITS), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .div_clock  (div_clock),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef LAP_HOLD_EN
    .lap        (lap),
    .lap_active (lap_active),
`endif
    .bcd        (bcd),
    .running    (running),
    .rollover   (rollover)
  );

  always #50 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: plain integer count and state; tick derived from the history of
  // div_clock samples (high two edges ago, low three edges ago).
  int m_state, m_next, m_count, m_snap;
  bit m_running, m_roll, m_hold, m_tick, m_counted;
  bit h0, h1, h2;
  bit lap_in;

`ifdef LAP_HOLD_EN
  assign lap_in = lap;
`else
  assign lap_in = 1'b0;
`endif

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state = S_IDLE; m_count = 0; m_snap = 0;
      m_running = 0; m_roll = 0; m_hold = 0;
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      m_tick    = h1 && !h2;
      m_counted = !clear && (m_state == S_RUN) && m_tick;
      m_roll    = m_counted && (m_count == MAXC);
      if (clear) m_hold = 0;
      else if (lap_in && m_state == S_RUN) begin
        if (!m_hold) m_snap = m_count;
        m_hold = !m_hold;
      end
      if (clear)          m_count = 0;
      else if (m_counted) m_count = (m_count + 1) % (MAXC + 1);
      m_next = m_state;
      if (clear) m_next = S_IDLE;
      else if (start_stop) m_next = (m_state == S_RUN) ? S_PAUSE : S_RUN;
      m_state   = m_next;
      m_running = (m_state == S_RUN);
      h2 = h1; h1 = h0; h0 = div_clock;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_bcd", 32'(bcd), 32'(to_bcd(m_hold ? m_snap : m_count)));
      check("model_running", 32'(running), 32'(m_running));
      check("model_rollover", 32'(rollover), 32'(m_roll));
`ifdef LAP_HOLD_EN
      check("model_lap_active", 32'(lap_active), 32'(m_hold));
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clock);
    start_stop = 1'b0;
  endtask

  task automatic div_pulses(input int n, input int hi, input int lo);
    repeat (n) begin
      div_clock = 1'b1;
      repeat (hi) @(negedge clock);
      div_clock = 1'b0;
      repeat (lo) @(negedge clock);
    end
  endtask

  int roll_hits;

  initial begin
    // Reset held with div_clock toggling
    #10 reset_n = 1'b0;
    @(negedge clock);
    cmp_en = 1'b1;
    repeat (10) begin
      div_clock = ~div_clock;
      @(negedge clock);
    end
    check("reset_bcd", 32'(bcd), 32'h0000);
    check("reset_running", 32'(running), 32'h0);
    check("reset_rollover", 32'(rollover), 32'h0);
    div_clock = 1'b0;
    reset_n   = 1'b1;
    div_pulses(20, 2, 2);
    idle(4);
    check("idle_no_count", 32'(bcd), 32'h0000);

    // Start and count 12, pinning the two-edge latency on the first edge
    pulse_ss();
    check("start_running", 32'(running), 32'h1);
    div_clock = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 check("latency_e1", 32'(bcd), 32'h0000);
    @(posedge clock);
    #1 check("latency_e2", 32'(bcd), 32'h0001);
    @(negedge clock);
    div_clock = 1'b0;
    idle(2);
    div_pulses(11, 3, 3);
    idle(4);
    check("count_12", 32'(bcd), 32'h0012);
    check("count_12_running", 32'(running), 32'h1);

    // Pause holds, resume continues
    pulse_ss();
    check("pause_running", 32'(running), 32'h0);
    div_pulses(5, 3, 3);
    idle(4);
    check("pause_hold", 32'(bcd), 32'h0012);
    pulse_ss();
    div_pulses(3, 3, 3);
    idle(4);
    check("resume_15", 32'(bcd), 32'h0015);

    // Fast run to all nines, then wrap
    div_pulses(MAXC - 15, 1, 1);
    idle(4);
    check("reach_9999", 32'(bcd), 32'h9999);
    div_clock = 1'b1;
    @(negedge clock);
    div_clock = 1'b0;
    roll_hits = 0;
    repeat (8) begin
      @(negedge clock);
      if (rollover) roll_hits++;
    end
    check("wrap_bcd", 32'(bcd), 32'h0000);
    check("wrap_pulse_count", 32'(roll_hits), 32'd1);
    check("wrap_running", 32'(running), 32'h1);

    // Async reset mid-count with a tick in flight
    div_pulses(7, 1, 1);
    div_clock = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #20 reset_n = 1'b0;
    #1 check("async_reset_bcd", 32'(bcd), 32'h0000);
    check("async_reset_running", 32'(running), 32'h0);
    @(negedge clock);
    reset_n   = 1'b1;
    div_clock = 1'b0;
    idle(4);
    check("post_reset_bcd", 32'(bcd), 32'h0000);

    // clear + tick + start_stop in the same cycle at 0042
    pulse_ss();
    div_pulses(42, 1, 1);
    idle(3);
    check("count_42", 32'(bcd), 32'h0042);
    div_clock = 1'b1;
    @(negedge clock);
    @(negedge clock);
    clear      = 1'b1;
    start_stop = 1'b1;
    @(negedge clock);
    clear      = 1'b0;
    start_stop = 1'b0;
    div_clock  = 1'b0;
    check("clear_prio_bcd", 32'(bcd), 32'h0000);
    check("clear_prio_running", 32'(running), 32'h0);
    idle(4);
    check("clear_idle_hold", 32'(bcd), 32'h0000);

`ifdef LAP_HOLD_EN
    pulse_ss();
    div_pulses(5, 1, 1);
    idle(3);
    check("lap_pre_5", 32'(bcd), 32'h0005);
    lap = 1'b1;
    @(negedge clock);
    lap = 1'b0;
    div_pulses(3, 1, 1);
    idle(3);
    check("lap_frozen", 32'(bcd), 32'h0005);
    check("lap_active_on", 32'(lap_active), 32'h1);
    lap = 1'b1;
    @(negedge clock);
    lap = 1'b0;
    check("lap_release", 32'(bcd), 32'h0008);
    check("lap_active_off", 32'(lap_active), 32'h0);
    idle(2);
`endif

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
